// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - fetch FSM state encoding and instruction/address bus widths
`ifndef InstBus
`define InstBus 31:0
`endif
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif

package inst_fetch_unit_pkg;

    localparam int INST_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_RD3  = 3'd4,
        ST_DONE = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped one-word-per-line instruction cache with lookup and fill ports
module icache_dm
    import inst_fetch_unit_pkg::*;
#(
    parameter int WADDR_W = 30,
    parameter int LINES   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WADDR_W-1:0] i_lookup_waddr,
    output logic               o_hit,
    output logic [INST_W-1:0]  o_data,
    input  logic               i_fill_en,
    input  logic [WADDR_W-1:0] i_fill_waddr,
    input  logic [INST_W-1:0]  i_fill_data
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = WADDR_W - IDX_W;

    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [INST_W-1:0] r_data [LINES];
    logic [LINES-1:0]  r_valid;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_fl_idx;

    assign w_lk_idx = i_lookup_waddr[IDX_W-1:0];
    assign w_lk_tag = i_lookup_waddr[WADDR_W-1:IDX_W];
    assign w_fl_idx = i_fill_waddr[IDX_W-1:0];

    assign o_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign o_data = r_data[w_lk_idx];

    // Only the valid bits need reset; tag/data are qualified by them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_fill_en) begin
            r_valid[w_fl_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[w_fl_idx]  <= i_fill_waddr[WADDR_W-1:IDX_W];
            r_data[w_fl_idx] <= i_fill_data;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - byte-serial instruction fetch front end; macro ICACHE_EN adds a direct-mapped cache
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int ICACHE_LINES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_ce_i,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    input  logic [7:0]        mem_din_i,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [`InstBus]   inst_o,
    output logic              inst_valid_o,
    output logic              stall_o
);

    if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_lines_check
        $error("ICACHE_LINES must be a power of two >= 2");
    end

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [23:0]       r_buf;
    logic [`InstBus]   r_inst;
    logic [ADDR_W-1:0] r_inst_addr;
    logic              r_valid;

    logic              w_accept;
    logic              w_abort;
    logic              w_done_ok;
    logic              w_hit;
    logic [`InstBus]   w_word;
    logic              w_mem_re;
    logic [ADDR_W-1:0] w_mem_addr;

    assign w_accept  = pc_ce_i && !flush_i;
    assign w_abort   = flush_i || (pc_ce_i && (pc_i != r_addr));
    assign w_done_ok = (r_state == ST_DONE) && !w_abort;
    assign w_word    = {mem_din_i, r_buf};

`ifdef ICACHE_EN
    logic [`InstBus] w_hit_data;

    icache_dm #(
        .WADDR_W (ADDR_W - 2),
        .LINES   (ICACHE_LINES)
    ) u_icache (
        .clk            (clk),
        .rst            (rst),
        .i_lookup_waddr (pc_i[ADDR_W-1:2]),
        .o_hit          (w_hit),
        .o_data         (w_hit_data),
        .i_fill_en      (w_done_ok),
        .i_fill_waddr   (r_addr[ADDR_W-1:2]),
        .i_fill_data    (w_word)
    );
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_mem_re     = 1'b0;
        w_mem_addr   = '0;
        case (r_state)
            ST_IDLE: if (w_accept && !w_hit) w_next_state = ST_RD0;
            ST_RD0: begin
                w_mem_re     = 1'b1;
                w_mem_addr   = r_addr;
                w_next_state = w_abort ? ST_IDLE : ST_RD1;
            end
            ST_RD1: begin
                w_mem_re     = 1'b1;
                w_mem_addr   = r_addr + ADDR_W'(1);
                w_next_state = w_abort ? ST_IDLE : ST_RD2;
            end
            ST_RD2: begin
                w_mem_re     = 1'b1;
                w_mem_addr   = r_addr + ADDR_W'(2);
                w_next_state = w_abort ? ST_IDLE : ST_RD3;
            end
            ST_RD3: begin
                w_mem_re     = 1'b1;
                w_mem_addr   = r_addr + ADDR_W'(3);
                w_next_state = w_abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Memory data trails the address by one cycle, so byte k lands in state RD(k+1)/DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_buf       <= '0;
            r_inst      <= '0;
            r_inst_addr <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_valid <= 1'b0;
            if ((r_state == ST_IDLE) && w_accept) r_addr <= pc_i;
            case (r_state)
                ST_RD1:  r_buf[7:0]   <= mem_din_i;
                ST_RD2:  r_buf[15:8]  <= mem_din_i;
                ST_RD3:  r_buf[23:16] <= mem_din_i;
                default: ;
            endcase
            if (w_done_ok) begin
                r_valid     <= 1'b1;
                r_inst      <= w_word;
                r_inst_addr <= r_addr;
            end
`ifdef ICACHE_EN
            if ((r_state == ST_IDLE) && w_accept && w_hit) begin
                r_valid     <= 1'b1;
                r_inst      <= w_hit_data;
                r_inst_addr <= pc_i;
            end
`endif
        end
    end

    assign mem_re_o     = w_mem_re;
    assign mem_addr_o   = w_mem_addr;
    assign inst_o       = r_inst;
    assign inst_addr_o  = r_inst_addr;
    assign inst_valid_o = r_valid;
    assign stall_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized bench for inst_fetch_unit against a transaction-level model
module tb_inst_fetch_unit;

    localparam int LINES = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_ce_i;
    logic        flush_i;
    logic [31:0] mem_addr_o;
    logic        mem_re_o;
    logic [7:0]  mem_din_i;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        stall_o;

    inst_fetch_unit #(.ADDR_W(32), .ICACHE_LINES(LINES)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_ce_i      (pc_ce_i),
        .flush_i      (flush_i),
        .mem_addr_o   (mem_addr_o),
        .mem_re_o     (mem_re_o),
        .mem_din_i    (mem_din_i),
        .inst_addr_o  (inst_addr_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .stall_o      (stall_o)
    );

    always #5 clk = ~clk;

    // 1 KiB instruction memory image, one-cycle read latency.
    logic [7:0] mem [1024];
    logic [7:0] r_mem;
    always @(posedge clk) r_mem <= mem[mem_addr_o[9:0]];
    assign mem_din_i = r_mem;

    int n_vec = 0;
    int n_err = 0;
    int ncyc = 0;
    int nstrobe = 0;
    int last_strobe_cyc = 0;
    bit saw_valid = 0;
    logic [31:0] addr_q[$];
    logic [31:0] pool[24];

    // Model: a fetch is either idle or m_off cycles past its acceptance.
    bit          m_busy = 0;
    int          m_off = 0;
    logic [31:0] m_A = 0;
    bit          m_valid = 0;
    logic [31:0] m_inst = 0;
    logic [31:0] m_iaddr = 0;
    bit          c_v[LINES];
    logic [31:0] c_w[LINES];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [9:0] b;
        b = a[9:0];
        return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_off = 0; m_A = 0; m_valid = 0; m_inst = 0; m_iaddr = 0;
        for (int i = 0; i < LINES; i++) c_v[i] = 0;
    endtask

    task automatic model_step(input bit ce, input logic [31:0] pc, input bit fl);
        int ln;
        m_valid = 0;
        if (m_busy) begin
            if (fl || (ce && pc != m_A)) begin
                m_busy = 0;
            end else if (m_off == 5) begin
                m_busy = 0;
                m_valid = 1;
                m_inst = word_at(m_A);
                m_iaddr = m_A;
`ifdef ICACHE_EN
                ln = int'((m_A >> 2) % LINES);
                c_v[ln] = 1;
                c_w[ln] = m_A >> 2;
`endif
            end else begin
                m_off++;
            end
        end else if (ce && !fl) begin
            ln = int'((pc >> 2) % LINES);
            if (c_v[ln] && c_w[ln] == (pc >> 2)) begin
                m_valid = 1;
                m_inst = word_at(pc);
                m_iaddr = pc;
            end else begin
                m_busy = 1;
                m_off = 1;
                m_A = pc;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    task automatic compare();
        bit rd;
        rd = m_busy && (m_off <= 4);
        chk("stall", {31'd0, stall_o}, {31'd0, m_busy});
        chk("mem_re", {31'd0, mem_re_o}, {31'd0, rd});
        chk("mem_addr", mem_addr_o, rd ? m_A + 32'(m_off - 1) : 32'd0);
        chk("inst_valid", {31'd0, inst_valid_o}, {31'd0, m_valid});
        chk("inst", inst_o, m_inst);
        chk("inst_addr", inst_addr_o, m_iaddr);
        saw_valid = inst_valid_o;
        if (inst_valid_o) begin
            nstrobe++;
            last_strobe_cyc = ncyc;
        end
        if (mem_re_o) addr_q.push_back(mem_addr_o);
    endtask

    task automatic cycle(input bit ce, input logic [31:0] pc, input bit fl);
        pc_ce_i = ce;
        pc_i = pc;
        flush_i = fl;
        model_step(ce, pc, fl);
        @(posedge clk);
        #1;
        ncyc++;
        compare();
    endtask

    task automatic run_until_strobe(input logic [31:0] pc, output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, pc, 1'b0);
            if (saw_valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL strobe_timeout: no strobe for pc %h within 20 cycles", pc);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int s1;
        int cnt;
        int r;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[16] = 8'h13; mem[17] = 8'h02; mem[18] = 8'h00; mem[19] = 8'h93;
        mem[64] = 8'hEF; mem[65] = 8'hBE; mem[66] = 8'hAD; mem[67] = 8'hDE;
        for (int i = 0; i < 24; i++)
            pool[i] = (i < 20) ? {22'd0, 8'($urandom), 2'b00} : {24'hFFFFFF, 6'($urandom), 2'b00};

        rst = 1; pc_i = 0; pc_ce_i = 0; flush_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        rst = 0;

        // single fetch at 0x10
        cycle(0, 0, 0);
        addr_q.delete();
        run_until_strobe(32'h10, lat);
        chk("single_latency", lat, 6);
        chk("single_inst", inst_o, 32'h93000213);
        chk("single_addr", inst_addr_o, 32'h10);
        chk("single_nreads", addr_q.size(), 4);
        for (int k = 0; k < 4 && k < addr_q.size(); k++) chk("single_rdaddr", addr_q[k], 32'h10 + k);

        // back-to-back: 0x0 then 0x4 in the strobe cycle
        run_until_strobe(32'h0, lat);
        s1 = last_strobe_cyc;
        run_until_strobe(32'h4, lat);
        chk("b2b_spacing", last_strobe_cyc - s1, 6);
        chk("b2b_addr", inst_addr_o, 32'h4);

        // redirect 0x8 -> 0x40 during RD2
        cnt = nstrobe;
        cycle(1, 32'h8, 0);
        cycle(1, 32'h8, 0);
        cycle(1, 32'h8, 0);
        cycle(1, 32'h40, 0);
        run_until_strobe(32'h40, lat);
        chk("redirect_latency", lat, 6);
        chk("redirect_nstrobe", nstrobe - cnt, 1);
        chk("redirect_inst", inst_o, 32'hDEADBEEF);
        chk("redirect_addr", inst_addr_o, 32'h40);

        // flush coinciding with DONE
        cnt = nstrobe;
        cycle(1, 32'h20, 0);
        repeat (4) cycle(1, 32'h20, 0);
        cycle(1, 32'h20, 1);
        repeat (3) cycle(0, 32'h20, 0);
        chk("flush_done_nostrobe", nstrobe - cnt, 0);
        run_until_strobe(32'h24, lat);
        chk("after_flush_latency", lat, 6);

        // asynchronous reset during RD1
        cycle(1, 32'h30, 0);
        cycle(1, 32'h30, 0);
        chk("pre_reset_stall", {31'd0, stall_o}, 32'd1);
        #2 rst = 1;
        #1;
        model_reset();
        compare();
        chk("reset_inst_zero", inst_o, 32'd0);
        @(posedge clk);
        #1;
        compare();
        rst = 0;
        run_until_strobe(32'h0, lat);
        chk("post_reset_latency", lat, 6);
        chk("post_reset_addr", inst_addr_o, 32'h0);

`ifdef ICACHE_EN
        run_until_strobe(32'h100, lat);
        chk("cache_miss_latency", lat, 6);
        addr_q.delete();
        run_until_strobe(32'h100, lat);
        chk("cache_hit_latency", lat, 1);
        chk("cache_hit_noreads", addr_q.size(), 0);
        run_until_strobe(32'h100 + 4 * LINES, lat);
        chk("cache_evict_latency", lat, 6);
        run_until_strobe(32'h100, lat);
        chk("cache_refetch_latency", lat, 6);
`endif

        for (int n = 0; n < 3000; n++) begin
            if (m_busy) begin
                r = $urandom_range(0, 99);
                if (r < 4)       cycle(0, m_A, 1);
                else if (r < 8)  cycle(1, pool[$urandom_range(0, 23)], 0);
                else if (r < 15) cycle(0, pool[$urandom_range(0, 23)], 0);
                else             cycle(1'($urandom_range(0, 1)), m_A, 0);
            end else begin
                cycle($urandom_range(0, 9) < 6, pool[$urandom_range(0, 23)], $urandom_range(0, 9) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch front end feeding the CPU core's instruction port; sits directly upstream of the core.
- Accepts the core's PC and fetch enable, reads four bytes from a byte-wide, 1-cycle-latency instruction memory, and assembles them little-endian into a 32-bit word.
- Returns the word, its address and a valid strobe to the core; holds a stall while a fetch is in progress.
- Aborts an in-flight fetch on redirect or flush.

Parameters:
- ADDR_W, 32, width of the PC and memory address.
- ICACHE_LINES, 64, number of direct-mapped cache lines. Power of two ≥2; used only with ICACHE_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_i  in  ADDR_W  fetch address from the core; must be word-aligned.
- pc_ce_i  in  1  fetch request enable.
- flush_i  in  1  cancel the in-flight fetch (branch/jump redirect).
- mem_addr_o  out  ADDR_W  byte address to instruction memory.
- mem_re_o  out  1  memory read enable.
- mem_din_i  in  8  memory read data; valid one cycle after the address is presented.
- inst_addr_o  out  ADDR_W  address of the returned instruction.
- inst_o  out  32  assembled instruction.
- inst_valid_o  out  1  one-cycle strobe: inst_o and inst_addr_o are valid.
- stall_o  out  1  fetch busy; the core must hold pc_i.

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0; byte buffer cleared; latched address cleared. Reset asserted mid-fetch aborts the fetch immediately with no valid pulse.
- FSM states: IDLE, RD0, RD1, RD2, RD3, DONE.
- IDLE → RD0: on a cycle with pc_ce_i=1 and flush_i=0, latch A=pc_i.
- RD0..RD3: mem_re_o=1, mem_addr_o=A+k for k=0..3 (sum taken modulo 2^ADDR_W, so the address wraps at the top of memory).
  - In RD1..RD3 and DONE, capture mem_din_i as byte k-1. Byte 0 goes to inst_o[7:0] (little-endian).
- RD3 → DONE. DONE captures byte 3, then registers the outputs: inst_valid_o=1 for exactly one cycle on the next cycle, with inst_o and inst_addr_o=A.
- After DONE, return to IDLE. A new request is accepted in the same cycle that inst_valid_o is high. Miss latency = 6 cycles from acceptance to the valid strobe.
- stall_o=1 in every non-IDLE state. stall_o=0 in IDLE and in the valid-strobe cycle.
- Holding outputs: inst_o and inst_addr_o hold their last value between strobes. mem_re_o=0 and mem_addr_o=0 outside RD0..RD3.
- Abort: flush_i=1, or pc_i≠A while pc_ce_i=1, in any state RD0..DONE.
  - Next state is IDLE; no valid strobe; partial bytes are discarded.
  - The new address is accepted from IDLE on a following cycle; it is never accepted in the same cycle as the abort.
- Simultaneous events: flush_i in IDLE blocks acceptance for that cycle. If flush_i and DONE coincide, the abort wins: no strobe.
- pc_ce_i=0 in IDLE: no memory activity; outputs hold.

Optional Feature:
- Macro: ICACHE_EN.
- Defined: a direct-mapped, one-word-per-line instruction cache is added.
  - Index = A[log2(ICACHE_LINES)+1:2]; tag = remaining upper bits; one valid bit per line.
  - Hit on acceptance in IDLE: the valid strobe comes on the next cycle, with no memory access and stall_o staying 0.
  - Miss: the normal byte fetch runs, and the line is written in DONE unless the fetch is aborted.
  - Valid bits are cleared only by rst. flush_i does not invalidate the cache.
- Undefined: no cache storage is built; every fetch takes the 6-cycle path.

Decomposition:
- Shared defines file holds the FSM state encodings and the instruction/address bus widths; reuse the existing InstBus/InstAddrBus defines.
- One sub-module, icache_dm: direct-mapped tag/data/valid arrays with a lookup port and a fill port. It is instantiated only under ICACHE_EN.

Test Plan:
- Single fetch: memory bytes at 0x10..0x13 = 13,02,00,93; pc_i=0x10, pc_ce_i=1 → mem_addr_o sequence 0x10..0x13; 6 cycles later, one-cycle inst_valid_o with inst_o=0x93000213 and inst_addr_o=0x10; stall_o high throughout the fetch.
- Back-to-back fetches: 0x0, then 0x4 presented in the strobe cycle → two strobes 6 cycles apart, with correct words.
- Redirect: pc_i changes 0x8→0x40 while in RD2 → no strobe for 0x8; a strobe for 0x40 with the memory word at 0x40.
- flush_i pulse in DONE → no strobe; IDLE; next request served normally.
- Reset mid-fetch: rst in RD1 → all outputs 0 immediately; after release, a fetch of 0x0 completes correctly.
- Cache (ICACHE_EN): fetch 0x100 twice → first takes 6 cycles with memory activity; second strobes 1 cycle after request with mem_re_o=0. Fetching 0x100+4·ICACHE_LINES evicts the line, so a refetch of 0x100 misses.
